// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM state encoding,
// RV64 load/store funct3 codes and the access-size decode.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Access size in bytes (1, 2, 4 or 8) from the low two funct3 bits.
    function automatic logic [3:0] f3_bytes(input logic [2:0] funct3);
        logic [3:0] size;
        case (funct3[1:0])
            2'd0:    size = 4'd1;
            2'd1:    size = 4'd2;
            2'd2:    size = 4'd4;
            default: size = 4'd8;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath for the load/store unit: request legality check,
// little-endian store lane merge and load extract with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            chk_write,
    input  logic [2:0]      chk_funct3,
    input  logic [2:0]      chk_offset,
    output logic            chk_error,

    input  logic [2:0]      op_funct3,
    input  logic [2:0]      op_offset,
    input  logic [XLEN-1:0] op_wdata,
    input  logic [XLEN-1:0] op_dword,
    output logic [XLEN-1:0] store_dword,
    output logic [XLEN-1:0] load_data
);

    logic            misaligned;
    logic            illegal;
    logic [5:0]      shamt;
    logic [8:0]      size_span;
    logic [7:0]      size_mask;
    logic [7:0]      lane_mask;
    logic [XLEN-1:0] wdata_shifted;
    logic [XLEN-1:0] dword_shifted;

    // Misaligned requests are flagged, never split across doublewords.
    always_comb begin
        misaligned = 1'b0;
        case (chk_funct3[1:0])
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = chk_offset[0];
            2'd2:    misaligned = |chk_offset[1:0];
            default: misaligned = |chk_offset;
        endcase
    end

    assign illegal   = chk_write ? chk_funct3[2] : (chk_funct3 == 3'b111);
    assign chk_error = misaligned | illegal;

    assign shamt         = {op_offset, 3'b000};
    assign size_span     = (9'd1 << f3_bytes(op_funct3)) - 9'd1;
    assign size_mask     = size_span[7:0];
    assign lane_mask     = size_mask << op_offset;
    assign wdata_shifted = op_wdata << shamt;
    assign dword_shifted = op_dword >> shamt;

    // Each byte lane either takes the shifted store byte or keeps memory.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign store_dword[gi*8 +: 8] = lane_mask[gi] ? wdata_shifted[gi*8 +: 8]
                                                          : op_dword[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        load_data = dword_shifted;
        case (op_funct3)
            F3_B:    load_data = {{(XLEN-8){dword_shifted[7]}},   dword_shifted[7:0]};
            F3_H:    load_data = {{(XLEN-16){dword_shifted[15]}}, dword_shifted[15:0]};
            F3_W:    load_data = {{(XLEN-32){dword_shifted[31]}}, dword_shifted[31:0]};
            F3_BU:   load_data = {{(XLEN-8){1'b0}},  dword_shifted[7:0]};
            F3_HU:   load_data = {{(XLEN-16){1'b0}}, dword_shifted[15:0]};
            F3_WU:   load_data = {{(XLEN-32){1'b0}}, dword_shifted[31:0]};
            default: load_data = dword_shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle RV64I load/store controller in front of a doubleword-only data
// memory; sub-doubleword stores are performed as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,

    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_error,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam logic [1:0] IDLE = 2'(ST_IDLE);
    localparam logic [1:0] RD   = 2'(ST_RD);
    localparam logic [1:0] WR   = 2'(ST_WR);
    localparam logic [1:0] RESP = 2'(ST_RESP);

    logic [1:0]        state_reg;
    logic [1:0]        state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [2:0]        funct3_reg;
    logic              write_reg;
    logic [XLEN-1:0]   wdata_reg;
    logic              error_reg;
    logic [XLEN-1:0]   dword_reg;

    logic              accept;
    logic              req_error;
    logic [XLEN-1:0]   store_dword;
    logic [XLEN-1:0]   load_data;
    logic [ADDR_W-1:0] dword_addr;

    assign req_ready  = (state_reg == IDLE);
    assign accept     = req_valid && req_ready;
    assign dword_addr = {addr_reg[ADDR_W-1:3], 3'b000};

    // Legality is judged on the live request; the data path uses latched fields.
    lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .chk_write   (req_write),
        .chk_funct3  (req_funct3),
        .chk_offset  (req_addr[2:0]),
        .chk_error   (req_error),
        .op_funct3   (funct3_reg),
        .op_offset   (addr_reg[2:0]),
        .op_wdata    (wdata_reg),
        .op_dword    (dword_reg),
        .store_dword (store_dword),
        .load_data   (load_data)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (req_error)
                        state_next = RESP;
                    else if (req_write && (req_funct3 == F3_D))
                        state_next = WR;
                    else
                        state_next = RD;
                end
            end
            RD:      state_next = write_reg ? WR : RESP;
            WR:      state_next = RESP;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= IDLE;
            addr_reg   <= '0;
            funct3_reg <= '0;
            write_reg  <= 1'b0;
            wdata_reg  <= '0;
            error_reg  <= 1'b0;
            dword_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                addr_reg   <= req_addr;
                funct3_reg <= req_funct3;
                write_reg  <= req_write;
                wdata_reg  <= req_wdata;
                error_reg  <= req_error;
            end
            if (state_reg == RD)
                dword_reg <= mem_rdata;
        end
    end

    assign mem_read    = (state_reg == RD);
    assign mem_rd_addr = (state_reg == RD) ? dword_addr : '0;

    // Gating with reset keeps an aborted store from landing on the reset edge.
    assign mem_write   = (state_reg == WR) && !reset;
    assign mem_wr_addr = (state_reg == WR) ? dword_addr : '0;

    always_comb begin
        mem_wdata = '0;
        if (state_reg == WR)
            mem_wdata = (funct3_reg == F3_D) ? wdata_reg : store_dword;
    end

    assign resp_valid = (state_reg == RESP);
    assign resp_error = (state_reg == RESP) && error_reg;

    always_comb begin
        resp_rdata = '0;
        if ((state_reg == RESP) && !write_reg && !error_reg)
            resp_rdata = load_data;
    end

endmodule
